// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-way round-robin arbiter with registered one-hot and index grant
// Optional hold limit enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter8 #(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 8
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld,
    output logic       timeout
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    if (HOLD_MAX < 1 || HOLD_MAX > 255 || (2 ** CNT_W) <= HOLD_MAX) begin : g_param_check
        $error("rr_arbiter8: HOLD_MAX must be 1..255 and fit in CNT_W bits");
    end

    logic [0:0] state;
    logic [2:0] ptr;
    logic [2:0] win_idx;
    logic [2:0] cand;
    logic       revoke;

    // Scan from ptr+7 down to ptr so the closest requester to ptr is written last and wins.
    always_comb begin
        win_idx = ptr;
        cand    = ptr;
        for (int k = 7; k >= 0; k--) begin
            cand = ptr + 3'(k);
            if (req[cand]) begin
                win_idx = cand;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;
    logic             timeout_q;

    assign revoke  = (state == S_GRANT) && req[gnt_idx] && (cnt == CNT_W'(HOLD_MAX));
    assign timeout = timeout_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt       <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= revoke;
            if (state == S_IDLE) begin
                if (|req) begin
                    cnt <= CNT_W'(1);
                end
            end else if (cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
`else
    assign revoke  = 1'b0;
    assign timeout = 1'b0;
`endif

    assign gnt_vld = |gnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= S_IDLE;
            ptr     <= 3'd0;
            gnt     <= 8'h00;
            gnt_idx <= 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req) begin
                        gnt     <= 8'(1) << win_idx;
                        gnt_idx <= win_idx;
                        state   <= S_GRANT;
                    end
                end
                default: begin
                    // A release and a revoke share the same exit; the pointer always moves past the holder.
                    if (!req[gnt_idx] || revoke) begin
                        gnt   <= 8'h00;
                        ptr   <= gnt_idx + 3'd1;
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - directed self-checking bench for rr_arbiter8
module tb_rr_arbiter8;

    logic       sys_clk;
    logic       sys_rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;
    logic [7:0] gnt4;
    logic [2:0] gnt_idx4;
    logic       gnt_vld4;
    logic       timeout4;

    int checks = 0;
    int errors = 0;

    rr_arbiter8 u_dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_vld   (gnt_vld),
        .timeout   (timeout)
    );

    rr_arbiter8 #(.HOLD_MAX(4), .CNT_W(8)) u_dut4 (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .req       (req),
        .gnt       (gnt4),
        .gnt_idx   (gnt_idx4),
        .gnt_vld   (gnt_vld4),
        .timeout   (timeout4)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    initial begin
        logic [7:0] exp_gnt;
        sys_rst_n = 1'b0;
        req       = 8'hFF;
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("rst_gnt", gnt, 8'h00);
        chk("rst_idx", {5'd0, gnt_idx}, 8'd0);
        chk("rst_vld", {7'd0, gnt_vld}, 8'd0);
        chk("rst_timeout", {7'd0, timeout}, 8'd0);
        sys_rst_n = 1'b1;
        step();

        // Fairness rotation: each winner drops its bit for one cycle.
        for (int i = 0; i < 9; i++) begin
            exp_gnt = 8'(1) << (i % 8);
            chk("rot_idx", {5'd0, gnt_idx}, 8'(i % 8));
            chk("rot_gnt", gnt, exp_gnt);
            chk("rot_vld", {7'd0, gnt_vld}, 8'd1);
            req = 8'hFF & ~exp_gnt;
            step();
            chk("rot_gap", {7'd0, gnt_vld}, 8'd0);
            req = 8'hFF;
            step();
        end
        // Holding idx 1 now; release so ptr = 2.
        req = 8'h00;
        step();
        chk("rel_vld", {7'd0, gnt_vld}, 8'd0);

        // Grant 4 to move ptr to 5, then 0 and 3 compete.
        req = 8'h10;
        step();
        chk("p4_idx", {5'd0, gnt_idx}, 8'd4);
        req = 8'h00;
        step();
        req = 8'b0000_1001;
        step();
        chk("wrap_idx", {5'd0, gnt_idx}, 8'd0);
        chk("wrap_gnt", gnt, 8'h01);
        req = 8'b0000_1000;
        step();
        chk("wrap_gap", {7'd0, gnt_vld}, 8'd0);
        step();
        chk("next_idx", {5'd0, gnt_idx}, 8'd3);
        chk("next_gnt", gnt, 8'h08);
        req = 8'h00;
        step();

        // No preemption: idx 2 holds while idx 6 waits.
        req = 8'h04;
        step();
        chk("hold_first", gnt, 8'h04);
        req = 8'h44;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_gnt", gnt, 8'h04);
        end
        req = 8'h40;
        step();
        chk("hold_gap", {7'd0, gnt_vld}, 8'd0);
        step();
        chk("after_hold", gnt, 8'h40);
        chk("after_idx", {5'd0, gnt_idx}, 8'd6);

        // Asynchronous reset in the middle of a grant on idx 7.
        req = 8'h80;
        step();
        step();
        chk("pre_rst_gnt", gnt, 8'h80);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk("async_gnt", gnt, 8'h00);
        chk("async_vld", {7'd0, gnt_vld}, 8'd0);
        chk("async_idx", {5'd0, gnt_idx}, 8'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        step();
        chk("post_rst_idx", {5'd0, gnt_idx}, 8'd7);
        chk("post_rst_gnt", gnt, 8'h80);

        // Constant single requester: hold limit behaviour.
        sys_rst_n = 1'b0;
        req = 8'h10;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        step();
`ifdef ARB_TIMEOUT_EN
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 4; c++) begin
                chk("to_vld", {7'd0, gnt_vld4}, 8'd1);
                chk("to_gnt", gnt4, 8'h10);
                chk("to_idx", {5'd0, gnt_idx4}, 8'd4);
                chk("to_quiet", {7'd0, timeout4}, 8'd0);
                step();
            end
            chk("to_pulse", {7'd0, timeout4}, 8'd1);
            chk("to_gap", {7'd0, gnt_vld4}, 8'd0);
            step();
        end
        chk("long_gnt", gnt, 8'h10);
        chk("long_timeout", {7'd0, timeout}, 8'd0);
`else
        for (int c = 0; c < 300; c++) begin
            chk("noto_gnt", gnt, 8'h10);
            chk("noto_timeout", {7'd0, timeout}, 8'd0);
            step();
        end
        chk("noto4_gnt", gnt4, 8'h10);
        chk("noto4_idx", {5'd0, gnt_idx4}, 8'd4);
        chk("noto4_vld", {7'd0, gnt_vld4}, 8'd1);
        chk("noto4_timeout", {7'd0, timeout4}, 8'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
